// File: rtl/mem_pkg.sv
// Shared DDR controller definitions: MIG command codes, read-side FSM encoding
// and default timing constants used by both the read and write controllers.
package mem_pkg;

  localparam logic [2:0] APP_CMD_READ  = 3'b001;
  localparam logic [2:0] APP_CMD_WRITE = 3'b000;

  localparam int DEF_ADDR_STEP = 8;
  localparam int DEF_TIMEOUT   = 8000;

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_CMD       = 2'd1,
    RD_WAIT_DATA = 2'd2,
    RD_DONE      = 2'd3
  } rd_state_e;

endpackage

// File: rtl/mem_read_ctrl.sv
// Read-burst controller: expands one granted burst into MIG read commands,
// forwards returned beats, and closes the burst with a finish pulse.
module mem_read_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_DATA_BITS = 256,
  parameter int ADDR_WIDTH    = 30,
  parameter int ADDR_STEP     = DEF_ADDR_STEP,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_n_i,
  input  logic                     rd_ddr_req,
  input  logic [7:0]               rd_ddr_len,
  input  logic [ADDR_WIDTH-1:0]    rd_ddr_addr,
  output logic                     rd_ddr_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_ddr_data,
  output logic                     rd_ddr_finish,
  output logic                     app_en,
  output logic [2:0]               app_cmd,
  output logic [ADDR_WIDTH-1:0]    app_addr,
  input  logic                     app_rdy,
  input  logic [MEM_DATA_BITS-1:0] app_rd_data,
  input  logic                     app_rd_data_valid,
  output logic                     rd_busy_o,
  output logic                     rd_timeout_o,
  output rd_state_e                rd_state_o
);

  rd_state_e             state, state_nxt;
  logic [7:0]            len_r, cmd_cnt, dat_cnt;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           wdog;
  logic                  in_xfer, accept, cmd_hs, beat_acc;
  logic                  last_cmd, last_dat, timeout_hit;

  // Command handshake: a command transfers in a cycle where app_en && app_rdy;
  // app_en and app_addr stay unchanged until that cycle.
  assign in_xfer     = (state == RD_CMD) || (state == RD_WAIT_DATA);
  assign accept      = (state == RD_IDLE) && rd_ddr_req && (rd_ddr_len != 8'd0);
  assign cmd_hs      = (state == RD_CMD) && app_rdy;
  assign beat_acc    = in_xfer && app_rd_data_valid;
  assign last_cmd    = cmd_hs && (cmd_cnt == len_r - 8'd1);
  assign last_dat    = beat_acc && (dat_cnt == len_r - 8'd1);
  // wdog holds completed cycles; the current cycle is wdog+1, so this fires
  // in the first cycle whose count exceeds TIMEOUT.
  assign timeout_hit = in_xfer && (wdog >= 16'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE: begin
        if (rd_ddr_req) state_nxt = (rd_ddr_len == 8'd0) ? RD_DONE : RD_CMD;
      end
      RD_CMD: begin
        if (timeout_hit) state_nxt = RD_DONE;
        else if (last_cmd)
          state_nxt = (last_dat || (dat_cnt == len_r)) ? RD_DONE : RD_WAIT_DATA;
      end
      RD_WAIT_DATA: begin
        if (timeout_hit || last_dat) state_nxt = RD_DONE;
      end
      RD_DONE:  state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      state             <= RD_IDLE;
      len_r             <= 8'd0;
      addr_r            <= '0;
      cmd_cnt           <= 8'd0;
      dat_cnt           <= 8'd0;
      wdog              <= 16'd0;
      rd_timeout_o      <= 1'b0;
      rd_ddr_data_valid <= 1'b0;
      rd_ddr_data       <= '0;
      rd_ddr_finish     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        len_r   <= rd_ddr_len;
        addr_r  <= rd_ddr_addr;
        cmd_cnt <= 8'd0;
        dat_cnt <= 8'd0;
      end else begin
        if (cmd_hs) begin
          cmd_cnt <= cmd_cnt + 8'd1;
          addr_r  <= addr_r + ADDR_WIDTH'(ADDR_STEP);
        end
        if (beat_acc) dat_cnt <= dat_cnt + 8'd1;
      end
      wdog <= (state == RD_IDLE) ? 16'd0 : wdog + 16'd1;
      if (timeout_hit) rd_timeout_o <= 1'b1;
      rd_ddr_data_valid <= beat_acc;
      if (beat_acc) rd_ddr_data <= app_rd_data;
      // Registered off DONE so the pulse lands one cycle after the last beat.
      rd_ddr_finish <= (state == RD_DONE);
    end
  end

  assign app_en     = (state == RD_CMD);
  assign app_cmd    = APP_CMD_READ;
  assign app_addr   = addr_r;
  assign rd_busy_o  = (state != RD_IDLE) || rd_ddr_finish;
  assign rd_state_o = state;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Self-checking bench for mem_read_ctrl: MIG responder model, command/data
// scoreboards and per-scenario tasks.
module tb_mem_read_ctrl;
  import mem_pkg::*;

  localparam int DW      = 256;
  localparam int AW      = 30;
  localparam int TIMEOUT = 8000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [7:0]    len = 8'd0;
  logic [AW-1:0] addr = '0;
  logic          dv;
  logic [DW-1:0] dd;
  logic          fin;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          tmo;
  rd_state_e     dut_state;

  logic          rsp_valid = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic          man_valid = 1'b0;
  logic [DW-1:0] man_data = '0;

  assign rd_valid = rsp_valid | man_valid;
  assign rd_data  = man_valid ? man_data : rsp_data;

  mem_read_ctrl #(
    .MEM_DATA_BITS(DW), .ADDR_WIDTH(AW), .ADDR_STEP(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .ddr_clk_i(clk), .ddr_rst_n_i(rst_n),
    .rd_ddr_req(req), .rd_ddr_len(len), .rd_ddr_addr(addr),
    .rd_ddr_data_valid(dv), .rd_ddr_data(dd), .rd_ddr_finish(fin),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_rd_data(rd_data), .app_rd_data_valid(rd_valid),
    .rd_busy_o(busy), .rd_timeout_o(tmo), .rd_state_o(dut_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            ret_q[$];
  bit            rdy_pat[$];

  int checks = 0, passes = 0;
  int cyc_n = 0;
  int n_hs = 0, n_en = 0, n_dv = 0, n_fin = 0;
  int fin_cyc = 0, last_dv_cyc = 0, busy_rise_cyc = 0;
  logic fin_busy = 1'b0;
  bit prev_busy = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int m_cyc;
  int rsp_lat = 10, rsp_budget = 1000;
  bit rsp_expect = 1, rdy_pat_en = 0;

  // monitor: samples on the falling edge, compares against the expected queues
  always @(negedge clk) begin
    cyc_n++;
    if (rst_n) begin
      if (app_en) begin
        n_en++;
        if (prev_stall) begin
          checks++;
          if (app_addr !== prev_addr)
            $display("FAIL addr_stable: app_addr %h, required %h", app_addr, prev_addr);
          else passes++;
        end
        if (app_rdy) begin
          n_hs++;
          checks++;
          if (exp_addr_q.size() == 0)
            $display("FAIL cmd_unexpected: app_addr %h, no command expected", app_addr);
          else begin
            m_addr = exp_addr_q.pop_front();
            if (app_addr !== m_addr || app_cmd !== APP_CMD_READ)
              $display("FAIL cmd: addr %h cmd %b, required addr %h cmd %b",
                       app_addr, app_cmd, m_addr, APP_CMD_READ);
            else passes++;
          end
          if (rsp_budget > 0) begin
            ret_q.push_back(cyc_n + rsp_lat);
            rsp_budget--;
          end
        end
      end
      prev_stall = app_en && !app_rdy;
      prev_addr  = app_addr;
      if (dv) begin
        n_dv++;
        last_dv_cyc = cyc_n;
        checks++;
        if (exp_q.size() == 0)
          $display("FAIL data_unexpected: rd_ddr_data %h, no beat expected", dd);
        else begin
          m_data = exp_q.pop_front();
          m_cyc  = exp_cyc_q.pop_front();
          if (dd !== m_data || cyc_n != m_cyc)
            $display("FAIL data_beat: %h at cycle %0d, required %h at cycle %0d",
                     dd, cyc_n, m_data, m_cyc);
          else passes++;
        end
      end
      if (fin) begin
        n_fin++;
        fin_cyc  = cyc_n;
        fin_busy = busy;
      end
      if (busy && !prev_busy) busy_rise_cyc = cyc_n;
      prev_busy = busy;
    end else begin
      prev_stall = 0;
      prev_busy  = 0;
    end
  end

  // MIG model: app_rdy pattern and read-data return after rsp_lat cycles
  always @(posedge clk) begin
    #1;
    if (rdy_pat_en && app_en) app_rdy = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    rsp_valid = 1'b0;
    if (ret_q.size() > 0 && ret_q[0] <= cyc_n + 1) begin
      ret_q.delete(0);
      rsp_valid = 1'b1;
      rsp_data  = {8{$urandom}};
      if (rsp_expect) begin
        exp_q.push_back(rsp_data);
        exp_cyc_q.push_back(cyc_n + 2);
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic start_burst(input int blen, input logic [AW-1:0] baddr, output int rcyc);
    logic [AW-1:0] a;
    a = baddr;
    for (int i = 0; i < blen; i++) begin
      exp_addr_q.push_back(a);
      a = a + AW'(8);
    end
    @(posedge clk); #1;
    req = 1'b1; len = 8'(blen); addr = baddr; rcyc = cyc_n + 1;
    @(posedge clk); #1;
    req = 1'b0; len = 8'($urandom_range(0, 255)); addr = AW'($urandom);
  endtask

  task automatic wait_finish(input int budget, input string name);
    int f0;
    f0 = n_fin;
    for (int i = 0; i < budget && n_fin == f0; i++) begin @(negedge clk); #1; end
    checks++;
    if (n_fin == f0) $display("FAIL %s_finish: no rd_ddr_finish within %0d cycles", name, budget);
    else passes++;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) $display("FAIL %s: got %0d, required %0d", name, got, want);
    else passes++;
  endtask

  // scenarios
  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    check_int("rst_app_en", int'(app_en), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_finish", int'(fin), 0);
    check_int("rst_dv", int'(dv), 0);
    check_int("rst_timeout", int'(tmo), 0);
    check_int("rst_app_addr", int'(app_addr), 0);
    check_int("rst_app_cmd", int'(app_cmd), int'(APP_CMD_READ));
    check_int("rst_state", int'(dut_state), int'(RD_IDLE));
    @(negedge clk); #2;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic;
    int h0, e0, d0, f0, r;
    rsp_lat = 10; rsp_budget = 1000; rdy_pat_en = 0; app_rdy = 1'b1;
    h0 = n_hs; e0 = n_en; d0 = n_dv; f0 = n_fin;
    start_burst(4, 30'h100, r);
    wait_finish(100, "basic");
    check_int("basic_busy_at_finish", int'(fin_busy), 1);
    check_int("basic_finish_after_last", fin_cyc, last_dv_cyc + 1);
    step(1);
    check_int("basic_busy_falls", int'(busy), 0);
    step(3);
    check_int("basic_handshakes", n_hs - h0, 4);
    check_int("basic_en_cycles", n_en - e0, 4);
    check_int("basic_beats", n_dv - d0, 4);
    check_int("basic_finishes", n_fin - f0, 1);
    check_int("basic_queues_empty", exp_addr_q.size() + exp_q.size(), 0);
  endtask

  task automatic test_backpressure;
    int h0, e0, f0, r;
    rsp_lat = 5;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rdy_pat_en = 1;
    h0 = n_hs; e0 = n_en; f0 = n_fin;
    start_burst(3, 30'h0, r);
    wait_finish(100, "bp");
    rdy_pat_en = 0; app_rdy = 1'b1;
    step(3);
    check_int("bp_handshakes", n_hs - h0, 3);
    check_int("bp_en_cycles", n_en - e0, 6);
    check_int("bp_finishes", n_fin - f0, 1);
    check_int("bp_queues_empty", exp_addr_q.size() + exp_q.size(), 0);
  endtask

  task automatic test_wrap_zero;
    int h0, e0, d0, r;
    rsp_lat = 3;
    h0 = n_hs;
    start_burst(2, 30'h3FFFFFF8, r);
    wait_finish(50, "wrap");
    step(1);
    check_int("wrap_handshakes", n_hs - h0, 2);
    check_int("wrap_queues_empty", exp_addr_q.size() + exp_q.size(), 0);
    e0 = n_en; d0 = n_dv;
    start_burst(0, 30'h1234, r);
    wait_finish(20, "zero");
    check_int("zero_finish_cycle", fin_cyc, r + 2);
    step(2);
    check_int("zero_no_app_en", n_en - e0, 0);
    check_int("zero_no_beats", n_dv - d0, 0);
  endtask

  task automatic test_timeout;
    int h0, d0, r;
    rsp_lat = 3; rsp_budget = 1;
    h0 = n_hs; d0 = n_dv;
    start_burst(2, 30'h40, r);
    wait_finish(TIMEOUT + 50, "timeout");
    check_int("timeout_finish_cycle", fin_cyc - busy_rise_cyc, TIMEOUT + 2);
    check_int("timeout_flag", int'(tmo), 1);
    check_int("timeout_handshakes", n_hs - h0, 2);
    check_int("timeout_beats", n_dv - d0, 1);
    rsp_budget = 1000;
    step(1);
    d0 = n_dv;
    start_burst(1, 30'h200, r);
    wait_finish(50, "after_timeout");
    check_int("after_timeout_beats", n_dv - d0, 1);
    check_int("after_timeout_order", fin_cyc, last_dv_cyc + 1);
    check_int("timeout_sticky", int'(tmo), 1);
    check_int("after_timeout_queues", exp_addr_q.size() + exp_q.size(), 0);
  endtask

  task automatic test_reset_mid;
    int h0, d0, f0, r, guard;
    rsp_lat = 4; rsp_expect = 0;
    h0 = n_hs; d0 = n_dv; f0 = n_fin;
    start_burst(5, 30'h500, r);
    guard = 0;
    while (n_hs - h0 < 2 && guard < 20) begin step(1); guard++; end
    check_int("rmid_two_handshakes", n_hs - h0, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_int("rmid_app_en", int'(app_en), 0);
    check_int("rmid_app_addr", int'(app_addr), 0);
    check_int("rmid_busy", int'(busy), 0);
    check_int("rmid_timeout_cleared", int'(tmo), 0);
    check_int("rmid_state", int'(dut_state), int'(RD_IDLE));
    @(negedge clk); #2;
    rst_n = 1'b1;
    exp_addr_q.delete();
    step(10);
    check_int("rmid_no_late_beats", n_dv - d0, 0);
    check_int("rmid_no_finish", n_fin - f0, 0);
    check_int("rmid_handshakes", n_hs - h0, 2);
    rsp_expect = 1;
    d0 = n_dv;
    start_burst(1, 30'h7F8, r);
    wait_finish(50, "rmid_next");
    check_int("rmid_next_beats", n_dv - d0, 1);
    check_int("rmid_next_queues", exp_addr_q.size() + exp_q.size(), 0);
  endtask

  task automatic test_stray;
    int d0, r;
    d0 = n_dv;
    @(posedge clk); #1;
    man_valid = 1'b1; man_data = {8{$urandom}};
    @(posedge clk); #1;
    man_data = {8{$urandom}};
    @(posedge clk); #1;
    man_valid = 1'b0;
    step(3);
    check_int("stray_dropped", n_dv - d0, 0);
    rsp_lat = 2;
    start_burst(2, 30'h900, r);
    wait_finish(50, "stray_next");
    check_int("stray_next_beats", n_dv - d0, 2);
    check_int("stray_next_order", fin_cyc, last_dv_cyc + 1);
    check_int("stray_next_queues", exp_addr_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_zero();
    test_timeout();
    test_reset_mid();
    test_stray();
    step(5);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
